// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic       PORT_CPU = 1'b0;
    localparam logic       PORT_DMA = 1'b1;
    localparam logic [3:0] WE_ALL   = 4'b1111;

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-way round-robin grant, one-hot output
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // Under contention the port that did not win last time goes first.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = (i_last_grant == PORT_CPU) ? 2'b10 : 2'b01;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - CPU/DMA arbiter in front of a single-port synchronous memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mem_rd_enable,
    output logic [3:0]            mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  r_last_grant;
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
    logic [1:0]            w_grant;
    logic                  w_hs;
    logic                  w_hs_port;

    mem_arb_rr u_rr (
        .i_valid0     (p0_valid),
        .i_valid1     (p1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // resetn gates ready so nothing looks accepted while reset is held low.
    assign p0_ready  = resetn && (r_state == IDLE) && w_grant[0];
    assign p1_ready  = resetn && (r_state == IDLE) && w_grant[1];
    assign w_hs      = (p0_valid && p0_ready) || (p1_valid && p1_ready);
    assign w_hs_port = p1_ready ? PORT_DMA : PORT_CPU;

    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wdata;
    assign p0_rdata    = r_rdata0;
    assign p1_rdata    = r_rdata1;

    always_comb begin
        w_next_state  = r_state;
        mem_rd_enable = 1'b0;
        mem_wr_enable = 4'b0000;
        p0_rvalid     = 1'b0;
        p1_rvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs) w_next_state = ISSUE;
            end
            ISSUE: begin
                if (r_we) begin
                    mem_wr_enable = WE_ALL;
                    w_next_state  = IDLE;
                end else begin
                    mem_rd_enable = 1'b1;
                    w_next_state  = RWAIT;
                end
            end
            RWAIT: w_next_state = RESP;
            RESP: begin
                p0_rvalid    = (r_port == PORT_CPU);
                p1_rvalid    = (r_port == PORT_DMA);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_DMA;
            r_port       <= PORT_CPU;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hs) begin
                r_last_grant <= w_hs_port;
                r_port       <= w_hs_port;
                r_we         <= w_hs_port ? p1_we    : p0_we;
                r_addr       <= w_hs_port ? p1_addr  : p0_addr;
                r_wdata      <= w_hs_port ? p1_wdata : p0_wdata;
            end
            // Memory returns data one cycle after the strobe, i.e. during RWAIT.
            if (r_state == RWAIT) begin
                if (r_port == PORT_CPU) r_rdata0 <= mem_rd_data;
                else                    r_rdata1 <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a memory model and read scoreboard
module tb_mem_arbiter;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          p0_valid = 1'b0, p1_valid = 1'b0;
    logic          p0_we = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_rd_enable;
    logic [3:0]    mem_wr_enable;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr_enable != 4'b0000) mem[mem_addr] <= mem_wr_data;
        if (mem_rd_enable)            mem_rd_data   <= mem[mem_addr];
    end

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        rsp_t r;
        if (p0_rvalid || p1_rvalid) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
            end else begin
                r = sb.pop_front();
                check("rvalid_port", {30'd0, p1_rvalid, p0_rvalid}, r.port ? 32'd2 : 32'd1);
                check("rdata", r.port ? p1_rdata : p0_rdata, r.data);
                check("read_latency", cyc - r.cyc, 32'd3);
            end
        end
    end

    task automatic drive(input bit port, input bit v, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (!port) begin
            p0_valid = v; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = v; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    function automatic logic rdy(input bit port);
        return port ? p1_ready : p0_ready;
    endfunction

    // Called just after a rising edge; returns just after the edge that leaves ISSUE.
    task automatic access(input vec_t v, output int hs);
        int   w;
        rsp_t r;
        hs = -1;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        w = 0;
        @(negedge clk);
        while (!rdy(v.port) && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("access_ready", w < 20, 1);
        if (w < 20) begin
            hs = cyc;
            if (!v.we) begin
                r.port = v.port; r.data = v.exp; r.cyc = cyc;
                sb.push_back(r);
            end
            @(posedge clk); #1;
            drive(v.port, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            check("issue_wr_enable", mem_wr_enable, v.we ? 32'hF : 32'h0);
            check("issue_rd_enable", mem_rd_enable, !v.we);
            check("issue_addr", mem_addr, v.addr);
            if (v.we) check("issue_wdata", mem_wr_data, v.wdata);
        end else begin
            drive(v.port, 1'b0, 1'b0, '0, '0);
        end
        @(posedge clk); #1;
    endtask

    task automatic contend(input bit first, input int n,
                           input logic [AW-1:0] a0, input logic [DW-1:0] e0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] e1);
        bit   exp_port;
        int   w;
        rsp_t r;
        exp_port = first;
        drive(1'b0, 1'b1, 1'b0, a0, '0);
        drive(1'b1, 1'b1, 1'b0, a1, '0);
        for (int k = 0; k < n; k++) begin
            w = 0;
            @(negedge clk);
            while (!(p0_ready || p1_ready) && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("contend_ready", w < 20, 1);
            if (w >= 20) break;
            check("grant_order", {30'd0, p1_ready, p0_ready}, exp_port ? 32'd2 : 32'd1);
            r.port = exp_port; r.data = exp_port ? e1 : e0; r.cyc = cyc;
            sb.push_back(r);
            exp_port = !exp_port;
            @(posedge clk); #1;
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {30'd0, p1_ready, p0_ready}, 0);
        check("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 0);
        check("rst_rdata", {p1_rdata, p0_rdata}, 0);
        check("rst_mem_strobes", {mem_wr_enable, mem_rd_enable}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        vec_t v;
        int   hs, prev_hs, w;

        vecs[0] = '{1'b0, 1'b1, 12'h010, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 12'h010, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 1'b1, 12'hFFF, 8'h3C, 8'h00};
        vecs[3] = '{1'b1, 1'b1, 12'h000, 8'hC3, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 12'h000, 8'h00, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 12'h7FF, 8'h5A, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 12'h7FF, 8'h00, 8'h5A};
        vecs[8] = '{1'b0, 1'b0, 12'h000, 8'h00, 8'hC3};

        // Reset with both requesters pending: nothing may be accepted.
        drive(1'b0, 1'b1, 1'b0, 12'h123, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 12'h456, 8'h00);
        repeat (2) @(negedge clk);
        check_reset_outputs();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        resetn = 1'b1;

        prev_hs = 0;
        for (int i = 0; i < 9; i++) begin
            access(vecs[i], hs);
            if (i > 0 && vecs[i].we && vecs[i-1].we && vecs[i].port == vecs[i-1].port)
                check("b2b_write_spacing", hs - prev_hs, 2);
            prev_hs = hs;
        end
        drain();
        check("p0_rdata_hold", p0_rdata, 8'hC3);
        check("p1_rdata_undisturbed", p1_rdata, 8'h5A);

        // p0 pulses valid only while a p1 write is in ISSUE.
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 12'h200, 8'h11);
        @(negedge clk);
        check("p1_ready_idle", p1_ready, 1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 1'b1, 12'h300, 8'hEE);
        @(negedge clk);
        check("p0_ready_in_issue", p0_ready, 0);
        check("issue_p1_addr", mem_addr, 12'h200);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("no_phantom_strobe", {mem_wr_enable, mem_rd_enable}, 0);
            check("no_phantom_addr", mem_addr, 12'h200);
            check("no_phantom_wdata", mem_wr_data, 8'h11);
        end
        @(posedge clk); #1;
        contend(1'b0, 2, 12'h010, 8'hA5, 12'hFFF, 8'h3C);
        drain();

        // Reset during RWAIT of a p1 read aborts it.
        @(posedge clk); #1;
        v = '{1'b1, 1'b0, 12'hFFF, 8'h00, 8'h3C};
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        w = 0;
        @(negedge clk);
        while (!p1_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("abort_ready", w < 20, 1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        resetn = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 12'h010, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 12'hFFF, 8'h00);
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        resetn = 1'b1;
        contend(1'b0, 4, 12'h010, 8'hA5, 12'hFFF, 8'h3C);
        drain();
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data width of both requester ports and the memory port.
REQ-002 Parameter ADDR_WIDTH, default 12, address width of both requester ports and the memory port.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 p0_valid / p1_valid  input  1 each  requester N has an access pending; port 0 is the CPU, port 1 is the loader/DMA.
REQ-006 p0_ready / p1_ready  output  1 each  arbiter accepts requester N this cycle; handshake completes when valid and ready are both high.
REQ-007 p0_we / p1_we  input  1 each  1 = write, 0 = read.
REQ-008 p0_addr / p1_addr  input  ADDR_WIDTH each  access address.
REQ-009 p0_wdata / p1_wdata  input  DATA_WIDTH each  write data.
REQ-010 p0_rvalid / p1_rvalid  output  1 each  one-cycle pulse; read data for requester N is valid.
REQ-011 p0_rdata / p1_rdata  output  DATA_WIDTH each  registered read data.
REQ-012 mem_rd_enable  output  1  read strobe to the memory block.
REQ-013 mem_wr_enable  output  4  byte-lane write enables to the memory block.
REQ-014 mem_addr  output  ADDR_WIDTH  memory address.
REQ-015 mem_wr_data  output  DATA_WIDTH  memory write data.
REQ-016 mem_rd_data  input  DATA_WIDTH  memory read data, valid the cycle after the memory samples a read (no output register).

Function
REQ-017 FSM states: IDLE, ISSUE, RWAIT, RESP.
REQ-018 Readiness: ready is asserted only in IDLE, and only to the granted port; ready is a combinational function of the state, both valids and last_grant.
REQ-019 Arbitration: if one port is valid, that port is granted; if both are valid, the port not equal to last_grant is granted (round-robin).
REQ-020 last_grant updates to the accepted port on each handshake.
REQ-021 Handshake in IDLE (cycle N): capture we, addr, wdata and the port index into registers, then go to ISSUE.
REQ-022 ISSUE (cycle N+1): drive mem_addr and mem_wr_data from the captured registers.
REQ-023 ISSUE, write: mem_wr_enable = 4'b1111, mem_rd_enable = 0, next state IDLE; a write occupies 2 cycles and produces no rvalid.
REQ-024 ISSUE, read: mem_rd_enable = 1, mem_wr_enable = 0, next state RWAIT.
REQ-025 RWAIT (cycle N+2): register mem_rd_data into the captured port's rdata register, then go to RESP.
REQ-026 RESP (cycle N+3): pulse rvalid of the captured port for exactly one cycle, then go to IDLE; read latency from handshake to rvalid is 3 cycles.
REQ-027 Inactive-state outputs: outside ISSUE, mem_rd_enable = 0 and mem_wr_enable = 0; mem_addr and mem_wr_data hold their last values.
REQ-028 rdata of each port holds its value until that port's next read completes; the other port's rdata is never disturbed.
REQ-029 The next handshake is possible in the IDLE cycle immediately following RESP or a write ISSUE; no request is accepted outside IDLE.
REQ-030 A requester deasserting valid before the handshake is legal; nothing is captured and no grant is consumed.
REQ-031 Address wrap-around is not applicable: addresses pass through unmodified at ADDR_WIDTH bits.

Reset
REQ-032 On resetn low: state = IDLE, last_grant = 1 (so port 0 wins the first contention), all captured registers = 0.
REQ-033 On resetn low: p0/p1_ready = 0 while in reset, p0/p1_rvalid = 0, p0/p1_rdata = 0.
REQ-034 On resetn low: mem_rd_enable = 0, mem_wr_enable = 0, mem_addr = 0, mem_wr_data = 0.
REQ-035 Reset asserted mid-access aborts the access; no rvalid is ever produced for it.

Structure
REQ-036 Package mem_arb_pkg holds the FSM state encoding, port index constants (PORT_CPU = 0, PORT_DMA = 1) and the WE_ALL = 4'b1111 constant.
REQ-037 The round-robin grant logic is a sub-module mem_arb_rr (inputs: two valids and last_grant; output: one-hot grant).
REQ-038 The FSM and datapath registers live in mem_arbiter.

Verification
REQ-039 After reset, p0 writes 0xA5 to 0x010 -> mem_wr_enable = 4'hF with mem_addr = 0x010 one cycle after the handshake; no rvalid.
REQ-040 p0 reads 0x010 after that write -> p0_rvalid pulses 3 cycles after the handshake with p0_rdata = 0xA5; p1_rvalid stays 0.
REQ-041 p0 and p1 both hold valid reads from reset -> grants alternate p0, p1, p0, p1; each rvalid returns to its own port with the correct data.
REQ-042 p1 alone issues back-to-back writes to 0xFFF and 0x000 -> accepted every 2 cycles; subsequent reads return the written values.
REQ-043 resetn pulsed low during RWAIT of a p1 read -> no p1_rvalid; all outputs at reset values; the first post-reset contention grants p0.
REQ-044 p0_valid raised and dropped while the arbiter is in ISSUE -> no capture, no memory strobe, and last_grant unchanged.
